// File: rtl/arbiter_merge_n_if.sv
// Handshake bundle for arbiter_merge_n: NUM_IN request channels merged onto one output stream.
// The DUT connects through the slave modport and the traffic source through the master modport.
interface arbiter_merge_n_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
);
  localparam int SRC_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SRC_W-1:0]        out_src;
  logic                    out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/arbiter_merge_n.sv
// Round-robin N-to-1 merge with optional packet lock and a 2-entry registered output FIFO.
// The output word, its source index and out_valid all come straight from flops.
module arbiter_merge_n #(
  parameter int WIDTH     = 8,
  parameter int NUM_IN    = 4,
  parameter int LOCK_MODE = 0
) (
  input logic             clk,
  input logic             reset,
  arbiter_merge_n_if.slave bus
);
  localparam int SRC_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int ENT_W = SRC_W + WIDTH;
  localparam bit LOCK_EN = (LOCK_MODE != 0);

  logic [1:0]       count_q, count_d;
  logic [ENT_W-1:0] head_q, head_d;
  logic [ENT_W-1:0] tail_q, tail_d;
  logic             out_valid_q, out_valid_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [SRC_W-1:0] lock_id_q, lock_id_d;

  logic [SRC_W:0]      scan_s;
  logic [SRC_W-1:0]    grant_s;
  logic                found_s;
  logic [NUM_IN-1:0]   in_ready_s;
  logic                push_s;
  logic                pop_s;
  logic [WIDTH-1:0]    push_data_s;
  logic [ENT_W-1:0]    push_ent_s;

  // Grant search from rr_ptr with wrap; a held lock pins the grant to lock_id.
  always_comb begin
    scan_s  = '0;
    grant_s = '0;
    found_s = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      scan_s = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      if (scan_s >= (SRC_W+1)'(NUM_IN)) begin
        scan_s = scan_s - (SRC_W+1)'(NUM_IN);
      end else begin
        scan_s = scan_s;
      end
      if (!found_s && bus.in_valid[scan_s[SRC_W-1:0]]) begin
        found_s = 1'b1;
        grant_s = scan_s[SRC_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
    if (lock_q) begin
      grant_s = lock_id_q;
      found_s = bus.in_valid[lock_id_q];
    end else begin
      grant_s = grant_s;
    end
  end

  // A channel is only readied while it requests, so an idle locked owner stalls everyone.
  always_comb begin
    in_ready_s  = '0;
    push_data_s = '0;
    if (!reset && found_s && (count_q != 2'd2)) begin
      in_ready_s[grant_s] = 1'b1;
    end else begin
      in_ready_s = '0;
    end
    for (int k = 0; k < NUM_IN; k++) begin
      if (SRC_W'(k) == grant_s) begin
        push_data_s = bus.in_data[k*WIDTH +: WIDTH];
      end else begin
        push_data_s = push_data_s;
      end
    end
  end

  assign push_s     = |in_ready_s;
  assign pop_s      = out_valid_q & bus.out_ready;
  assign push_ent_s = {grant_s, push_data_s};

  // FIFO, round-robin pointer and lock next-state.
  always_comb begin
    count_d   = count_q;
    head_d    = head_q;
    tail_d    = tail_q;
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    case ({push_s, pop_s})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = push_ent_s;
        end else begin
          tail_d = push_ent_s;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = push_ent_s;
        end else begin
          head_d = tail_q;
          tail_d = push_ent_s;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
    if (push_s) begin
      rr_ptr_d = (grant_s == SRC_W'(NUM_IN - 1)) ? '0 : grant_s + SRC_W'(1);
      if (LOCK_EN) begin
        lock_d    = ~push_data_s[WIDTH-1];
        lock_id_d = grant_s;
      end else begin
        lock_d = 1'b0;
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    out_valid_d = (count_d != 2'd0);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
    end else begin
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = head_q[WIDTH-1:0];
  assign bus.out_src   = head_q[ENT_W-1:WIDTH];
endmodule

// File: doc/arbiter_merge_n.md
ARBITER_MERGE_N -- requirements
Module: arbiter_merge_n

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, payload bits per input.
REQ-002 The module SHALL have parameter NUM_IN, default 4, input channel count, legal range 2..16.
REQ-003 The module SHALL have parameter LOCK_MODE, default 0; 1 = packet lock, with data bit WIDTH-1 as the tail flag.
REQ-004 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The module SHALL have port in_valid  input  NUM_IN  per-input request; bit i belongs to channel i.
REQ-007 The module SHALL have port in_data  input  NUM_IN*WIDTH  channel i payload at bits [i*WIDTH +: WIDTH].
REQ-008 The module SHALL have port in_ready  output  NUM_IN  per-input accept; at most one bit set per cycle.
REQ-009 The module SHALL have port out_valid  output  1  output holds a word.
REQ-010 The module SHALL have port out_data  output  WIDTH  merged payload.
REQ-011 The module SHALL have port out_src  output  $clog2(NUM_IN)  index of the channel that supplied out_data.
REQ-012 The module SHALL have port out_ready  input  1  downstream accept.

Function
REQ-013 A transfer on channel i SHALL occur in a cycle where in_valid[i] and in_ready[i] are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-014 The block SHALL contain a 2-entry registered output FIFO holding {src, data}, with count in 0..2.
REQ-015 in_ready SHALL be all zero when count==2 or reset==1, with no bypass of a same-cycle pop.
REQ-016 The grant SHALL be combinational: the first requesting channel found searching from rr_ptr upward with wrap NUM_IN-1 -> 0; in_ready[grant]=1 only when count<2.
REQ-017 After an input transfer from channel g, rr_ptr SHALL become (g+1) mod NUM_IN; with no input transfer, rr_ptr SHALL hold.
REQ-018 With LOCK_MODE=1, an accepted word with tail bit 0 SHALL set lock with lock_id=g; while locked, only channel lock_id SHALL be granted, even if its in_valid is 0.
REQ-019 With LOCK_MODE=1, an accepted word with tail bit 1 from lock_id SHALL clear lock in the same edge, and rr_ptr SHALL then advance per REQ-017.
REQ-020 With LOCK_MODE=0, the tail bit SHALL be ignored and lock SHALL stay 0.
REQ-021 Latency SHALL be 1 cycle: a word accepted at edge k into an empty FIFO is on out_data/out_src with out_valid=1 after edge k.
REQ-022 The FIFO SHALL preserve acceptance order; simultaneous push and pop SHALL leave count unchanged.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_src SHALL stay stable.
REQ-024 An input that deasserts in_valid before being accepted SHALL lose no state; the arbiter simply re-evaluates.

Reset
REQ-025 While reset=1 at a rising edge, the following SHALL all become 0 regardless of other inputs: count, rr_ptr, lock, lock_id, out_valid, out_data, out_src.
REQ-026 in_ready SHALL be 0 in every cycle reset=1; no transfer SHALL be recorded in that cycle.
REQ-027 Reset asserted mid-packet SHALL discard FIFO contents and any active lock.
REQ-028 The first cycle after reset release SHALL arbitrate from channel 0.

Verification
REQ-029 Bench SHALL drive NUM_IN=4, all in_valid=1, data=i, out_ready=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles after a 1-cycle fill.
REQ-030 Bench SHALL drive out_ready=0 with ch2 sending 0xA1 then 0xA2 -> count=2, in_ready=0000, out_data held at 0xA1; then out_ready=1 -> 0xA1 then 0xA2 in order.
REQ-031 Bench SHALL run LOCK_MODE=1 with ch1 sending 0x01,0x02,0x83 and ch0/ch3 valid throughout -> all three ch1 words are consecutive, then grant goes to ch3 (rr_ptr=2, ch2 idle).
REQ-032 Bench SHALL run LOCK_MODE=1 with ch1 locked and in_valid[1] dropping for 3 cycles while ch0 is valid -> in_ready stays 0000 for those 3 cycles and ch0 is not accepted.
REQ-033 Bench SHALL assert reset for 1 cycle with count=2 and lock=1 -> next cycle out_valid=0, lock=0, and grant goes to the lowest valid channel.
REQ-034 Bench SHALL run a random-stall soak of 10k cycles against a reference model -> no loss, duplication or reorder per source, and at most one in_ready bit set per cycle.
